// File: rtl/pattern_gen.sv
// pattern_gen: raster-synchronous test-pattern source for the vga_driver colour inputs.
// Runs its own h/v counters with the driver's timing. It registers one pixel per clock,
// one cycle behind the counters. The pattern selection is latched at the last pixel of
// each frame, so a new mode starts cleanly at pixel (0,0).
module pattern_gen #(
  parameter int vga_width    = 1024,
  parameter int vga_height   = 768,
  parameter int color_depth  = 8,
  parameter int h_front_cnt  = 24,
  parameter int h_sync_cnt   = 136,
  parameter int h_back_cnt   = 144,
  parameter int v_front_cnt  = 3,
  parameter int v_sync_cnt   = 6,
  parameter int v_back_cnt   = 29,
  parameter int checker_log2 = 6,
  parameter int grad_shift   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             mode,
  input  logic [2:0]             color_sel,
  output logic [color_depth-1:0] r_out,
  output logic [color_depth-1:0] g_out,
  output logic [color_depth-1:0] b_out,
  output logic [10:0]            pix_x,
  output logic [9:0]             pix_y,
  output logic                   active,
  output logic                   frame_start
);

  localparam int H_TOTAL = vga_width + h_front_cnt + h_sync_cnt + h_back_cnt;
  localparam int V_TOTAL = vga_height + v_front_cnt + v_sync_cnt + v_back_cnt;
  localparam int BAR_W   = vga_width / 8;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(vga_width);
  localparam logic [9:0]  V_ACT    = 10'(vga_height);
  localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
  localparam logic [color_depth-1:0] C_ON = '1;

  logic [10:0] hc;
  logic [9:0]  vc;
  logic [7:0]  frame_cnt;
  logic [2:0]  mode_r;
  logic [2:0]  color_r;
  logic [2:0]  bar_idx;
  logic [10:0] bar_cnt;

  logic h_last;
  logic v_last;
  assign h_last = (hc == H_LAST);
  assign v_last = (vc == V_LAST);

  // Raster counters plus the once-per-frame latch of mode, colour and frame count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc        <= '0;
      vc        <= '0;
      frame_cnt <= '0;
      mode_r    <= '0;
      color_r   <= '0;
    end else begin
      if (h_last) begin
        hc <= '0;
        vc <= v_last ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 11'd1;
      end
      if (h_last && v_last) begin
        mode_r    <= mode;
        color_r   <= color_sel;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Colour-bar index tracks hc without a divider: restart at line start, step every BAR_W pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (h_last) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (bar_cnt == BAR_LAST) begin
      bar_cnt <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_cnt <= bar_cnt + 11'd1;
    end
  end

  logic                   vis;
  logic                   checker_on;
  logic [10:0]            bar_rel;
  logic                   mbar_on;
  logic [2:0]             rgb_on;
  logic                   use_grad;
  logic [color_depth-1:0] grad;
  logic [color_depth-1:0] pix_r;
  logic [color_depth-1:0] pix_g;
  logic [color_depth-1:0] pix_b;

  // Pixel colour for the current counter position; blanked outside the visible area.
  always_comb begin
    vis        = (hc < H_ACT) && (vc < V_ACT);
    checker_on = hc[checker_log2] ^ vc[checker_log2];
    // Unsigned 11-bit difference: pixels left of the bar wrap to large values and stay dark.
    bar_rel    = hc - {1'b0, frame_cnt, 2'b00};
    mbar_on    = (bar_rel <= 11'd63);
    grad       = color_depth'(hc >> grad_shift);
    rgb_on     = 3'b000;
    use_grad   = 1'b0;
    case (mode_r)
      3'd0: rgb_on = color_r;
      3'd1: begin
        case (bar_idx)
          3'd0:    rgb_on = 3'b111;
          3'd1:    rgb_on = 3'b110;
          3'd2:    rgb_on = 3'b011;
          3'd3:    rgb_on = 3'b010;
          3'd4:    rgb_on = 3'b101;
          3'd5:    rgb_on = 3'b100;
          3'd6:    rgb_on = 3'b001;
          default: rgb_on = 3'b000;
        endcase
      end
      3'd2:    rgb_on = {3{checker_on}};
      3'd3:    use_grad = 1'b1;
      3'd4:    rgb_on = {3{mbar_on}};
      default: rgb_on = 3'b000;
    endcase
    pix_r = use_grad ? grad : (rgb_on[2] ? C_ON : '0);
    pix_g = use_grad ? grad : (rgb_on[1] ? C_ON : '0);
    pix_b = use_grad ? grad : (rgb_on[0] ? C_ON : '0);
    if (!vis) begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
    end
  end

  // Register all pixel outputs together so colour, position and flags stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_out       <= pix_r;
      g_out       <= pix_g;
      b_out       <= pix_b;
      pix_x       <= hc;
      pix_y       <= vc;
      active      <= vis;
      frame_start <= (hc == 11'd0) && (vc == 10'd0);
    end
  end

endmodule
